// File: rtl/dso_pkg.sv
// Shared types and widths for the DSO acquisition front end (ADC reader).
package dso_pkg;

    localparam int SAMPLE_W = 12;
    localparam int LZ_BITS  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        QUIET = 2'd3
    } adc_state_t;

    function automatic logic lz_violation(input logic [LZ_BITS-1:0] lz);
        return |lz;
    endfunction

endpackage

// File: rtl/adc_spi_reader_sclk_gen.sv
// SPI serial clock generator: half-period counter plus the sclk flop.
// sclk idles high; stop_i parks it high instead of starting another low phase.
module adc_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic active_i,
    input  logic stop_i,
    output logic sclk_o,
    output logic phase_end_o,
    output logic sample_tick_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sclk_q;
    logic             sclk_d;
    logic             phase_end_s;

    // Half-period counting and sclk toggle decision
    always_comb begin
        cnt_d       = cnt_q;
        sclk_d      = sclk_q;
        phase_end_s = active_i && (cnt_q == CNT_LAST);
        if (!active_i) begin
            cnt_d  = '0;
            sclk_d = 1'b1;
        end else if (phase_end_s) begin
            cnt_d  = '0;
            sclk_d = stop_i ? 1'b1 : ~sclk_q;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            sclk_d = sclk_q;
        end
    end

    // Counter and sclk registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o        = sclk_q;
    assign phase_end_o   = phase_end_s;
    assign sample_tick_o = phase_end_s & sclk_q;

endmodule

// File: rtl/adc_spi_reader.sv
// AD7476-style 12-bit SPI ADC reader with continuous conversion.
// Optional leading-zero frame check is built when ADC_LZ_CHECK_EN is defined.
module adc_spi_reader
    import dso_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int QUIET_CYC  = 8,
    parameter int FRAME_BITS = 16
) (
    input  logic                CLK,
    input  logic                RSTB,
    input  logic                en,
    input  logic                adc_sdata,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic [SAMPLE_W-1:0] DATA_OUT,
    output logic                data_valid,
    output logic                busy,
    output logic                frame_err
);

    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int Q_W   = (QUIET_CYC > 1) ? $clog2(QUIET_CYC + 1) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(QUIET_CYC - 1);
`ifdef ADC_LZ_CHECK_EN
    localparam int SHIFT_W = SAMPLE_W + LZ_BITS - 1;
`else
    localparam int SHIFT_W = SAMPLE_W - 1;
`endif

    adc_state_t          state_q;
    adc_state_t          state_d;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [BIT_W-1:0]    bit_cnt_d;
    logic [Q_W-1:0]      quiet_cnt_q;
    logic [Q_W-1:0]      quiet_cnt_d;
    logic [SHIFT_W-1:0]  shift_q;
    logic [SHIFT_W-1:0]  shift_d;
    logic [SHIFT_W:0]    shift_next_s;
    logic [SAMPLE_W-1:0] data_q;
    logic [SAMPLE_W-1:0] data_d;
    logic                sync1_q;
    logic                sync2_q;
    logic                cs_n_q;
    logic                busy_q;
    logic                valid_q;
    logic                active_s;
    logic                frame_done_s;
    logic                phase_end_s;
    logic                sample_tick_s;

    assign active_s     = (state_q == SETUP) || (state_q == SHIFT);
    assign frame_done_s = (state_q == SHIFT) && sample_tick_s && (bit_cnt_q == BIT_LAST);
    assign shift_next_s = {shift_q, sync2_q};

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i         (CLK),
        .rst_n_i       (RSTB),
        .active_i      (active_s),
        .stop_i        (frame_done_s),
        .sclk_o        (adc_sclk),
        .phase_end_o   (phase_end_s),
        .sample_tick_o (sample_tick_s)
    );

    // Next-state, bit/quiet counting and sample capture
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        quiet_cnt_d = quiet_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                bit_cnt_d   = '0;
                quiet_cnt_d = '0;
                state_d     = en ? SETUP : IDLE;
            end
            SETUP: begin
                state_d = phase_end_s ? SHIFT : SETUP;
            end
            SHIFT: begin
                if (sample_tick_s) begin
                    shift_d = shift_next_s[SHIFT_W-1:0];
                    if (frame_done_s) begin
                        bit_cnt_d   = '0;
                        quiet_cnt_d = '0;
                        data_d      = shift_next_s[SAMPLE_W-1:0];
                        state_d     = QUIET;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            QUIET: begin
                if (quiet_cnt_q == Q_LAST) begin
                    quiet_cnt_d = '0;
                    state_d     = en ? SETUP : IDLE;
                end else begin
                    quiet_cnt_d = quiet_cnt_q + Q_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, synchroniser and registered outputs
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            sync1_q     <= adc_sdata;
            sync2_q     <= sync1_q;
            cs_n_q      <= !((state_d == SETUP) || (state_d == SHIFT));
            busy_q      <= (state_d != IDLE);
            valid_q     <= frame_done_s;
        end
    end

`ifdef ADC_LZ_CHECK_EN
    logic frame_err_q;

    // Leading-zero violation flag, aligned with the data strobe
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_done_s && lz_violation(shift_next_s[SHIFT_W:SAMPLE_W]);
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign adc_cs_n   = cs_n_q;
    assign DATA_OUT   = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Self-checking bench for adc_spi_reader: ADC serial model plus expected-sample scoreboard.
module tb_adc_spi_reader;

    localparam int CLK_DIV    = 4;
    localparam int QUIET_CYC  = 8;
    localparam int FRAME_BITS = 16;
    localparam int FRAME_CYC  = CLK_DIV * (1 + 2 * FRAME_BITS);
    localparam int PERIOD_CYC = FRAME_CYC + QUIET_CYC;

    logic        CLK = 1'b0;
    logic        RSTB;
    logic        en;
    logic        adc_sdata;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [11:0] DATA_OUT;
    logic        data_valid;
    logic        busy;
    logic        frame_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

`ifdef ADC_LZ_CHECK_EN
    logic lz_en = 1'b1;
`else
    logic lz_en = 1'b0;
`endif

    adc_spi_reader #(
        .CLK_DIV    (CLK_DIV),
        .QUIET_CYC  (QUIET_CYC),
        .FRAME_BITS (FRAME_BITS)
    ) dut (
        .CLK        (CLK),
        .RSTB       (RSTB),
        .en         (en),
        .adc_sdata  (adc_sdata),
        .adc_cs_n   (adc_cs_n),
        .adc_sclk   (adc_sclk),
        .DATA_OUT   (DATA_OUT),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // ADC model: first bit on cs_n fall, next bits on later sclk falls
    logic [15:0] tx_q[$];
    logic [11:0] exp_data_q[$];
    logic        exp_lz_q[$];
    logic [15:0] cur_word;
    logic [15:0] default_word = 16'h03E8;
    int          bit_idx = 0;
    int          nfall   = 0;

    always @(negedge adc_cs_n) begin
        if (tx_q.size() > 0) cur_word = tx_q.pop_front();
        else cur_word = default_word;
        bit_idx   = 0;
        nfall     = 0;
        adc_sdata = cur_word[15];
        exp_data_q.push_back(cur_word[11:0]);
        exp_lz_q.push_back(|cur_word[15:12]);
    end

    always @(negedge adc_sclk) begin
        if (adc_cs_n === 1'b0) begin
            nfall = nfall + 1;
            if (nfall > 1 && bit_idx < 15) begin
                bit_idx   = bit_idx + 1;
                adc_sdata = cur_word[15 - bit_idx];
            end
        end
    end

    // Event monitor: cs_n falls and strobes, timestamped in CLK edges
    int   fall_cnt  = 0;
    int   fall_cyc  = 0;
    int   valid_cnt = 0;
    int   valid_cyc = 0;
    logic prev_cs   = 1'b1;

    always @(negedge CLK) begin
        if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
            fall_cnt = fall_cnt + 1;
            fall_cyc = cyc;
        end
        prev_cs = adc_cs_n;
        if (data_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_fall(input int max_cyc, output bit seen);
        int f0;
        f0   = fall_cnt;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (fall_cnt != f0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (data_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic pop_exp(output logic [11:0] d, output logic lz, output bit ok);
        ok = (exp_data_q.size() > 0);
        d  = 12'h000;
        lz = 1'b0;
        if (ok) begin
            d  = exp_data_q.pop_front();
            lz = exp_lz_q.pop_front();
        end
    endtask

    task automatic go_idle();
        bit done;
        en   = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 2 * PERIOD_CYC; i++) begin
            step();
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL go_idle: busy=%b required 0 within budget", busy);
        end
    endtask

    task automatic test_reset();
        RSTB = 1'b0;
        en   = 1'b0;
        adc_sdata = 1'b0;
        repeat (3) step();
        tests_run++;
        if (adc_cs_n !== 1'b1) begin tests_failed++; $display("FAIL rst_cs_n: got %b required 1", adc_cs_n); end
        tests_run++;
        if (adc_sclk !== 1'b1) begin tests_failed++; $display("FAIL rst_sclk: got %b required 1", adc_sclk); end
        tests_run++;
        if (DATA_OUT !== 12'h000) begin tests_failed++; $display("FAIL rst_data: got %0d required 0", DATA_OUT); end
        tests_run++;
        if ({data_valid, busy, frame_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rst_flags: valid/busy/err got %b required 000", {data_valid, busy, frame_err});
        end
        RSTB = 1'b1;
        repeat (5) step();
        tests_run++;
        if (adc_cs_n !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_hold: cs_n=%b busy=%b required 1/0", adc_cs_n, busy);
        end
    endtask

    task automatic test_single();
        bit          seen;
        bit          ok;
        logic [11:0] ed;
        logic        elz;
        int          f0;
        en = 1'b1;
        wait_fall(5, seen);
        f0 = fall_cyc;
        tests_run++;
        if (!seen || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL t1_start: cs fall seen=%0d busy=%b required 1/1", seen, busy);
        end
        wait_valid(FRAME_CYC + 20, seen);
        pop_exp(ed, elz, ok);
        tests_run++;
        if (!seen || !ok) begin
            tests_failed++;
            $display("FAIL t1_valid: seen=%0d sb=%0d required 1/1", seen, ok);
        end
        tests_run++;
        if (valid_cyc - f0 !== FRAME_CYC) begin
            tests_failed++;
            $display("FAIL t1_latency: got %0d required %0d", valid_cyc - f0, FRAME_CYC);
        end
        tests_run++;
        if (DATA_OUT !== ed || ed !== 12'd1000) begin
            tests_failed++;
            $display("FAIL t1_data: got %0d required %0d", DATA_OUT, ed);
        end
        tests_run++;
        if (adc_cs_n !== 1'b1 || frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_cs_err: cs_n=%b err=%b required 1/0", adc_cs_n, frame_err);
        end
        en = 1'b0;
        step();
        tests_run++;
        if (data_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_pulse_width: valid got %b required 0", data_valid);
        end
        go_idle();
        tests_run++;
        if (DATA_OUT !== 12'd1000) begin
            tests_failed++;
            $display("FAIL t1_hold: got %0d required 1000", DATA_OUT);
        end
    endtask

    task automatic test_back_to_back();
        bit          seen;
        bit          ok;
        logic [11:0] ed;
        logic        elz;
        int          prev_v;
        for (int i = 0; i < 7; i++) tx_q.push_back(16'(1000 + 2 * i));
        for (int i = 1; i <= 5; i++) tx_q.push_back(16'(1012 - 2 * i));
        prev_v = 0;
        en = 1'b1;
        for (int n = 0; n < 12; n++) begin
            wait_valid(PERIOD_CYC + 20, seen);
            if (n == 11) en = 1'b0;
            pop_exp(ed, elz, ok);
            tests_run++;
            if (!seen || !ok || DATA_OUT !== ed) begin
                tests_failed++;
                $display("FAIL t2_data[%0d]: got %0d required %0d (seen=%0d)", n, DATA_OUT, ed, seen);
            end
            if (n > 0) begin
                tests_run++;
                if (valid_cyc - prev_v !== PERIOD_CYC) begin
                    tests_failed++;
                    $display("FAIL t2_period[%0d]: got %0d required %0d", n, valid_cyc - prev_v, PERIOD_CYC);
                end
            end
            prev_v = valid_cyc;
        end
        go_idle();
    endtask

    task automatic test_en_drop();
        bit          seen;
        bit          ok;
        logic [11:0] ed;
        logic        elz;
        int          f0;
        int          fc;
        int          low_cnt;
        tx_q.push_back(16'h0123);
        en = 1'b1;
        wait_fall(5, seen);
        f0 = fall_cyc;
        for (int i = 0; i < 60 && (cyc - f0) < 50; i++) step();
        en = 1'b0;
        wait_valid(FRAME_CYC, seen);
        pop_exp(ed, elz, ok);
        tests_run++;
        if (!seen || !ok || DATA_OUT !== ed || valid_cyc - f0 !== FRAME_CYC) begin
            tests_failed++;
            $display("FAIL t3_frame: data %0d required %0d, latency %0d required %0d",
                     DATA_OUT, ed, valid_cyc - f0, FRAME_CYC);
        end
        for (int i = 0; i < 40 && busy === 1'b1; i++) step();
        tests_run++;
        if (busy !== 1'b0 || cyc - f0 !== PERIOD_CYC) begin
            tests_failed++;
            $display("FAIL t3_busy_fall: busy=%b at %0d required 0 at %0d", busy, cyc - f0, PERIOD_CYC);
        end
        fc      = fall_cnt;
        low_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (adc_cs_n !== 1'b1) low_cnt++;
        end
        tests_run++;
        if (low_cnt != 0 || fall_cnt != fc) begin
            tests_failed++;
            $display("FAIL t3_cs_quiet: low cycles %0d required 0", low_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        bit          seen;
        bit          ok;
        logic [11:0] ed;
        logic        elz;
        int          f0;
        int          v0;
        en = 1'b1;
        wait_fall(5, seen);
        f0 = fall_cyc;
        for (int i = 0; i < 80 && (cyc - f0) < 70; i++) step();
        v0 = valid_cnt;
        RSTB = 1'b0;
        #1;
        tests_run++;
        if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1) begin
            tests_failed++;
            $display("FAIL t4_async: cs_n=%b sclk=%b required 1/1", adc_cs_n, adc_sclk);
        end
        tests_run++;
        if (DATA_OUT !== 12'h000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_cleared: data=%0d busy=%b required 0/0", DATA_OUT, busy);
        end
        repeat (3) step();
        exp_data_q.delete();
        exp_lz_q.delete();
        RSTB = 1'b1;
        wait_fall(5, seen);
        f0 = fall_cyc;
        tests_run++;
        if (!seen || valid_cnt != v0 || DATA_OUT !== 12'h000) begin
            tests_failed++;
            $display("FAIL t4_no_strobe: strobes %0d required %0d, data %0d required 0",
                     valid_cnt, v0, DATA_OUT);
        end
        wait_valid(FRAME_CYC + 20, seen);
        pop_exp(ed, elz, ok);
        tests_run++;
        if (!seen || !ok || DATA_OUT !== ed || valid_cyc - f0 !== FRAME_CYC) begin
            tests_failed++;
            $display("FAIL t4_recover: data %0d required %0d, latency %0d required %0d",
                     DATA_OUT, ed, valid_cyc - f0, FRAME_CYC);
        end
        go_idle();
    endtask

    task automatic test_edges();
        bit          seen;
        bit          ok;
        logic [11:0] ed;
        logic        elz;
        int          setup_n;
        int          lo_n;
        int          hi_n;
        tx_q.push_back(16'h0000);
        tx_q.push_back(16'h0FFF);
        en = 1'b1;
        wait_fall(5, seen);
        setup_n = 0;
        while (adc_sclk === 1'b1 && setup_n < 20) begin setup_n++; step(); end
        lo_n = 0;
        while (adc_sclk === 1'b0 && lo_n < 20) begin lo_n++; step(); end
        hi_n = 0;
        while (adc_sclk === 1'b1 && hi_n < 20) begin hi_n++; step(); end
        tests_run++;
        if (setup_n != CLK_DIV || lo_n != CLK_DIV || hi_n != CLK_DIV) begin
            tests_failed++;
            $display("FAIL t5_sclk_phase: setup/low/high %0d/%0d/%0d required %0d each",
                     setup_n, lo_n, hi_n, CLK_DIV);
        end
        for (int n = 0; n < 2; n++) begin
            wait_valid(PERIOD_CYC + 20, seen);
            if (n == 1) en = 1'b0;
            pop_exp(ed, elz, ok);
            tests_run++;
            if (!seen || !ok || DATA_OUT !== ed) begin
                tests_failed++;
                $display("FAIL t5_edge[%0d]: got %h required %h", n, DATA_OUT, ed);
            end
        end
        go_idle();
    endtask

    task automatic test_lz();
        bit          seen;
        bit          ok;
        logic [11:0] ed;
        logic        elz;
        tx_q.push_back(16'h83E8);
        en = 1'b1;
        wait_valid(PERIOD_CYC + 20, seen);
        en = 1'b0;
        pop_exp(ed, elz, ok);
        tests_run++;
        if (!seen || !ok || DATA_OUT !== ed || ed !== 12'd1000) begin
            tests_failed++;
            $display("FAIL t6_data: got %0d required %0d", DATA_OUT, ed);
        end
        tests_run++;
        if (frame_err !== (elz & lz_en)) begin
            tests_failed++;
            $display("FAIL t6_frame_err: got %b required %b", frame_err, elz & lz_en);
        end
        step();
        tests_run++;
        if (frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t6_err_width: got %b required 0", frame_err);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_en_drop();
        test_reset_midframe();
        test_edges();
        test_lz();
        tests_run++;
        if (exp_data_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: %0d entries required 0", exp_data_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
